// File: rtl/cpu_debug_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_debug_pkg : shared constants and types for the CPU trace streamer     |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_debug_pkg;

  localparam logic [7:0] c_HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_META = 2'd1,
    ST_REGS = 2'd2,
    ST_MEM  = 2'd3
  } state_t;

  localparam int c_W_HDR      = 0;
  localparam int c_W_CYCLE    = 1;
  localparam int c_W_PC       = 2;
  localparam int c_W_STALL    = 3;
  localparam int c_W_FLUSH    = 4;
  localparam int c_META_WORDS = 5;

  function automatic int frame_len(input int nregs, input int nmem);
    return c_META_WORDS + nregs + nmem;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_trace_streamer_if.sv
// +--------------------------------------------------------------------------+
// | cpu_trace_streamer_if : framed 32-bit valid/ready trace word stream       |
// | Revision              : 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cpu_trace_streamer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

`default_nettype wire

// File: rtl/debug_counters.sv
// +--------------------------------------------------------------------------+
// | debug_counters : gated 32-bit cycle/stall/flush counters                  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module debug_counters (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        en_i,
  input  wire logic        stall_i,
  input  wire logic        flush_i,
  output logic [31:0]      cycle_nxt_o,
  output logic [31:0]      stall_nxt_o,
  output logic [31:0]      flush_nxt_o
);

  logic [31:0] r_cycle;
  logic [31:0] r_stall;
  logic [31:0] r_flush;

  // Next values are exported so a snapshot can include the current cycle's events.
  assign cycle_nxt_o = r_cycle + {31'd0, en_i};
  assign stall_nxt_o = r_stall + {31'd0, en_i & stall_i};
  assign flush_nxt_o = r_flush + {31'd0, en_i & flush_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle <= 32'd0;
      r_stall <= 32'd0;
      r_flush <= 32'd0;
    end else begin
      r_cycle <= cycle_nxt_o;
      r_stall <= stall_nxt_o;
      r_flush <= flush_nxt_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_trace_streamer.sv
// +--------------------------------------------------------------------------+
// | cpu_trace_streamer : freezes the CPU and streams a state snapshot frame   |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_trace_streamer
  import cpu_debug_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 8
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  input  wire logic               start_i,
  input  wire logic               snap_i,
  input  wire logic [31:0]        pc_i,
  input  wire logic               stall_i,
  input  wire logic               flush_i,
  output logic [4:0]              reg_addr_o,
  input  wire logic [31:0]        reg_data_i,
  output logic [31:0]             mem_addr_o,
  input  wire logic [31:0]        mem_data_i,
  output logic                    freeze_o,
  output logic                    busy_o,
  cpu_trace_streamer_if.master    strm
);

  localparam int c_FRAME_LEN = frame_len(NUM_REGS, MEM_WORDS);
  localparam int c_PW        = $clog2(c_FRAME_LEN + 1);

  localparam logic [c_PW-1:0] c_ONE_P      = c_PW'(1);
  localparam logic [c_PW-1:0] c_CYCLE_P    = c_PW'(c_W_CYCLE);
  localparam logic [c_PW-1:0] c_PC_P       = c_PW'(c_W_PC);
  localparam logic [c_PW-1:0] c_STALL_P    = c_PW'(c_W_STALL);
  localparam logic [c_PW-1:0] c_FLUSH_P    = c_PW'(c_W_FLUSH);
  localparam logic [c_PW-1:0] c_REG_P      = c_PW'(c_META_WORDS);
  localparam logic [c_PW-1:0] c_MEM_P      = c_PW'(c_META_WORDS + NUM_REGS);
  localparam logic [c_PW-1:0] c_LAST_P     = c_PW'(c_FRAME_LEN - 1);
  localparam logic [c_PW-1:0] c_REG_LAST_P = c_PW'(c_META_WORDS + NUM_REGS - 1);

  state_t          r_state;
  logic [c_PW-1:0] r_ptr;
  logic [15:0]     r_seq;
  logic [7:0]      r_drop_cnt;
  logic [7:0]      r_drop_rep;
  logic [31:0]     r_cyc;
  logic [31:0]     r_pc;
  logic [31:0]     r_stl;
  logic [31:0]     r_fls;

  logic [31:0]     w_cycle_nxt;
  logic [31:0]     w_stall_nxt;
  logic [31:0]     w_flush_nxt;
  logic [c_PW-1:0] w_nxt;
  logic            w_is_reg;
  logic            w_is_mem;
  logic            w_hs;
  logic            w_final;
  logic            w_drop;
  logic [7:0]      w_drop_sat;
  logic [31:0]     w_next_word;

  debug_counters u_counters (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (start_i & ~freeze_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .cycle_nxt_o (w_cycle_nxt),
    .stall_nxt_o (w_stall_nxt),
    .flush_nxt_o (w_flush_nxt)
  );

  assign w_nxt      = r_ptr + c_ONE_P;
  assign w_is_reg   = (w_nxt >= c_REG_P) && (w_nxt < c_MEM_P);
  assign w_is_mem   = (w_nxt >= c_MEM_P) && (w_nxt <= c_LAST_P);
  assign w_hs       = strm.out_valid & strm.out_ready;
  assign w_final    = w_hs && (r_ptr == c_LAST_P);
  assign w_drop     = snap_i && (r_state != ST_IDLE);
  assign w_drop_sat = (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;

  // Debug read addresses always point at the word that the next handshake loads.
  assign reg_addr_o = w_is_reg ? 5'(w_nxt - c_REG_P) : 5'd0;
  assign mem_addr_o = w_is_mem ? (32'(w_nxt - c_MEM_P) << 2) : 32'd0;

  always_comb begin
    w_next_word = mem_data_i;
    if (w_nxt == c_CYCLE_P)      w_next_word = r_cyc;
    else if (w_nxt == c_PC_P)    w_next_word = r_pc;
    else if (w_nxt == c_STALL_P) w_next_word = r_stl;
    else if (w_nxt == c_FLUSH_P) w_next_word = r_fls;
    else if (w_is_reg)           w_next_word = reg_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_seq          <= 16'd0;
      r_drop_cnt     <= 8'd0;
      r_drop_rep     <= 8'd0;
      r_cyc          <= 32'd0;
      r_pc           <= 32'd0;
      r_stl          <= 32'd0;
      r_fls          <= 32'd0;
      freeze_o       <= 1'b0;
      busy_o         <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= 32'd0;
      strm.out_last  <= 1'b0;
    end else begin
      if (w_drop) r_drop_cnt <= w_drop_sat;

      if (r_state == ST_IDLE) begin
        if (snap_i) begin
          r_state        <= ST_META;
          r_ptr          <= '0;
          r_cyc          <= w_cycle_nxt;
          r_pc           <= pc_i;
          r_stl          <= w_stall_nxt;
          r_fls          <= w_flush_nxt;
          freeze_o       <= 1'b1;
          busy_o         <= 1'b1;
          strm.out_valid <= 1'b1;
          strm.out_data  <= {c_HDR_MAGIC, r_drop_rep, r_seq};
          strm.out_last  <= 1'b0;
        end
      end else if (w_final) begin
        // Drops seen during this frame are reported in the next frame's header.
        r_state        <= ST_IDLE;
        r_ptr          <= '0;
        r_seq          <= r_seq + 16'd1;
        r_drop_rep     <= w_drop ? w_drop_sat : r_drop_cnt;
        r_drop_cnt     <= 8'd0;
        freeze_o       <= 1'b0;
        busy_o         <= 1'b0;
        strm.out_valid <= 1'b0;
        strm.out_data  <= 32'd0;
        strm.out_last  <= 1'b0;
      end else if (w_hs) begin
        r_ptr         <= w_nxt;
        strm.out_data <= w_next_word;
        strm.out_last <= (w_nxt == c_LAST_P);
        if (r_state == ST_META && r_ptr == c_FLUSH_P)
          r_state <= ST_REGS;
        else if (r_state == ST_REGS && r_ptr == c_REG_LAST_P)
          r_state <= ST_MEM;
      end
    end
  end

endmodule

`default_nettype wire
